fir_transposed_param: RTL and testbench

Parametrised transposed-form FIR filter core, the next generation of the team's fixed 33-tap reconfigurable FIR. Coefficients are written into a shadow bank at any time and committed atomically to the active bank on a sample boundary, so the coefficient set can change without glitches. Tap count, widths and output scaling are compile-time parameters, and the number of active taps is selectable at run time. It sits between the 300 kHz sample-enable domain logic and the output formatter, clocked by the 12 MHz system clock.

---
 rtl/fir_pkg.sv | 44 ++++
 rtl/fir_tap.sv | 52 +++++
 rtl/fir_transposed_param.sv | 191 +++++++++++++++++++
 tb/tb_fir_transposed_param.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types, width helpers and the output round/saturate function for the
// parametrised transposed-form FIR core.
package fir_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } swap_state_e;

    localparam int unsigned MIN_NTAPS = 32'd2;
    localparam int unsigned MAX_NTAPS = 32'd64;
    localparam int unsigned MAX_ADDR_W = $clog2(MAX_NTAPS);
    localparam int unsigned MAX_NUM_W  = $clog2(MAX_NTAPS + 32'd1);

    function automatic int unsigned addr_width(input int unsigned ntaps);
        return $clog2(ntaps);
    endfunction

    function automatic int unsigned count_width(input int unsigned ntaps);
        return $clog2(ntaps + 32'd1);
    endfunction

    // Round-half-up arithmetic shift, then optional clamp to a dout_w signed range.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] y,
                                                     input int unsigned        shift,
                                                     input int unsigned        dout_w,
                                                     input logic               sat_en);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (y + ((64'sd1 <<< shift) >>> 1)) >>> shift;
        hi = (64'sd1 <<< (dout_w - 32'd1)) - 64'sd1;
        lo = -(64'sd1 <<< (dout_w - 32'd1));
        if (sat_en && (r > hi)) begin
            r = hi;
        end else if (sat_en && (r < lo)) begin
            r = lo;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_tap.sv
// One transposed-form tap: product plus incoming partial sum, held in a
// clearable, enabled register (tap 0 passes the sum straight through as y).
module fir_tap
    import fir_pkg::*;
#(
    parameter int DIN_W   = 3,
    parameter int COEF_W  = 16,
    parameter int ACC_W   = 24,
    parameter bit HAS_REG = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     clr_i,
    input  logic signed [DIN_W-1:0]  x_i,
    input  logic signed [COEF_W-1:0] coef_i,
    input  logic signed [ACC_W-1:0]  zin_i,
    output logic signed [ACC_W-1:0]  out_o
);

    logic signed [DIN_W+COEF_W-1:0] prod_s;
    logic signed [ACC_W-1:0]        sum_s;
    logic signed [ACC_W-1:0]        z_d;
    logic signed [ACC_W-1:0]        z_q;

    assign prod_s = x_i * coef_i;
    assign sum_s  = ACC_W'(prod_s) + zin_i;

    // Next partial sum: a commit clear wins over the sample strobe.
    always_comb begin
        z_d = z_q;
        if (clr_i) begin
            z_d = {ACC_W{1'b0}};
        end else if (en_i) begin
            z_d = sum_s;
        end else begin
            z_d = z_q;
        end
    end

    // Partial-sum register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            z_q <= {ACC_W{1'b0}};
        end else begin
            z_q <= z_d;
        end
    end

    assign out_o = HAS_REG ? z_q : sum_s;

endmodule

// File: rtl/fir_transposed_param.sv
// Transposed-form FIR with shadow/active coefficient banks and sample-aligned
// commit. Define FIR_OUT_SAT_EN to saturate the output instead of wrapping it.
module fir_transposed_param
    import fir_pkg::*;
#(
    parameter int NTAPS     = 33,
    parameter int DIN_W     = 3,
    parameter int COEF_W    = 16,
    parameter int ACC_W     = 24,
    parameter int DOUT_W    = 16,
    parameter int OUT_SHIFT = 0
) (
    input  logic                             iClk_12M,
    input  logic                             iRst,
    input  logic                             iEnSample,
    input  logic signed [DIN_W-1:0]          iFirIn,
    input  logic                             iCoeffWrEn,
    input  logic [$clog2(NTAPS)-1:0]         iCoeffAddr,
    input  logic signed [COEF_W-1:0]         iCoeffWrDt,
    input  logic [$clog2(NTAPS+1)-1:0]       iNumOfCoeff,
    input  logic                             iCoeffSwap,
    output logic signed [DOUT_W-1:0]         oFirOut,
    output logic                             oFirValid,
    output logic                             oSwapPending,
    output logic                             oSwapDone,
    output logic                             oSettled
);

    localparam int ADDR_W = addr_width(NTAPS);
    localparam int NUM_W  = count_width(NTAPS);

`ifdef FIR_OUT_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    swap_state_e              state_q;
    swap_state_e              state_d;
    logic                     commit_s;
    logic                     wr_ok_s;
    logic [NUM_W-1:0]         nact_req_s;
    logic [NUM_W-1:0]         nact_q;
    logic [NUM_W-1:0]         settle_q;
    logic [NUM_W-1:0]         settle_d;
    logic signed [COEF_W-1:0] shadow_q [NTAPS];
    logic signed [COEF_W-1:0] active_q [NTAPS];
    logic signed [COEF_W-1:0] coef_s   [NTAPS];
    logic signed [ACC_W-1:0]  link_s   [NTAPS];
    logic signed [DOUT_W-1:0] out_s;
    logic signed [DOUT_W-1:0] fir_out_q;
    logic                     valid_q;
    logic                     done_q;

    assign wr_ok_s    = iCoeffWrEn && ({1'b0, iCoeffAddr} < (ADDR_W+1)'(NTAPS));
    assign nact_req_s = (iNumOfCoeff > NUM_W'(NTAPS)) ? NUM_W'(NTAPS) : iNumOfCoeff;

    // Swap FSM state register.
    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Swap FSM next state; a request in PEND is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = iCoeffSwap ? PEND : IDLE;
            PEND:    state_d = iEnSample  ? IDLE : PEND;
            default: state_d = IDLE;
        endcase
    end

    // Swap FSM outputs: commit happens on the first strobe seen while pending.
    always_comb begin
        commit_s = 1'b0;
        case (state_q)
            PEND:    commit_s = iEnSample;
            default: commit_s = 1'b0;
        endcase
    end

    // Coefficient banks; active copies the pre-write shadow on commit.
    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            for (int k = 0; k < NTAPS; k++) begin
                shadow_q[k] <= {COEF_W{1'b0}};
                active_q[k] <= {COEF_W{1'b0}};
            end
        end else begin
            for (int k = 0; k < NTAPS; k++) begin
                if (wr_ok_s && (iCoeffAddr == ADDR_W'(k))) begin
                    shadow_q[k] <= iCoeffWrDt;
                end
                if (commit_s) begin
                    active_q[k] <= shadow_q[k];
                end
            end
        end
    end

    // Taps at or beyond the active count contribute nothing.
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            coef_s[k] = {COEF_W{1'b0}};
            if (NUM_W'(k) < nact_q) begin
                coef_s[k] = active_q[k];
            end else begin
                coef_s[k] = {COEF_W{1'b0}};
            end
        end
    end

    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        logic signed [ACC_W-1:0] zin_s;
        if (k == NTAPS - 1) begin : g_last
            assign zin_s = {ACC_W{1'b0}};
        end else begin : g_mid
            assign zin_s = link_s[k+1];
        end
        fir_tap #(
            .DIN_W   (DIN_W),
            .COEF_W  (COEF_W),
            .ACC_W   (ACC_W),
            .HAS_REG (k != 0)
        ) u_tap (
            .clk_i  (iClk_12M),
            .rst_i  (iRst),
            .en_i   (iEnSample),
            .clr_i  (commit_s),
            .x_i    (iFirIn),
            .coef_i (coef_s[k]),
            .zin_i  (zin_s),
            .out_o  (link_s[k])
        );
    end

    // Settle counter: loaded with nAct-1 at commit, counts strobes down to zero.
    always_comb begin
        settle_d = settle_q;
        if (commit_s) begin
            settle_d = (nact_req_s == {NUM_W{1'b0}}) ? {NUM_W{1'b0}}
                                                     : nact_req_s - {{(NUM_W-1){1'b0}}, 1'b1};
        end else if (iEnSample && (settle_q != {NUM_W{1'b0}})) begin
            settle_d = settle_q - {{(NUM_W-1){1'b0}}, 1'b1};
        end else begin
            settle_d = settle_q;
        end
    end

    // Output shaping of y = link_s[0].
    always_comb begin
        out_s = DOUT_W'(round_sat(64'(link_s[0]), OUT_SHIFT, DOUT_W, SAT_EN));
        if (nact_q == {NUM_W{1'b0}}) begin
            out_s = {DOUT_W{1'b0}};
        end else begin
            out_s = DOUT_W'(round_sat(64'(link_s[0]), OUT_SHIFT, DOUT_W, SAT_EN));
        end
    end

    // Registered outputs, active tap count and settle counter.
    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            fir_out_q <= {DOUT_W{1'b0}};
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            nact_q    <= {NUM_W{1'b0}};
            settle_q  <= {NUM_W{1'b0}};
        end else begin
            valid_q  <= iEnSample;
            done_q   <= commit_s;
            settle_q <= settle_d;
            if (iEnSample) begin
                fir_out_q <= out_s;
            end
            if (commit_s) begin
                nact_q <= nact_req_s;
            end
        end
    end

    assign oFirOut      = fir_out_q;
    assign oFirValid    = valid_q;
    assign oSwapDone    = done_q;
    assign oSwapPending = (state_q == PEND);
    assign oSettled     = (settle_q == {NUM_W{1'b0}});

endmodule

// File: tb/tb_fir_transposed_param.sv
// Self-checking bench: direct-form convolution reference over the input
// history since the last commit, driven by directed and random stimulus.
module tb_fir_transposed_param;

    localparam int NT  = 5;
    localparam int DW  = 3;
    localparam int CW  = 16;
    localparam int AW  = 24;
    localparam int OW  = 16;
    localparam int SH  = 0;
    localparam int ADW = $clog2(NT);
    localparam int NW  = $clog2(NT + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic signed [DW-1:0] din;
    logic                 wr;
    logic [ADW-1:0]       addr;
    logic signed [CW-1:0] wdat;
    logic [NW-1:0]        num;
    logic                 swap;
    logic signed [OW-1:0] dout;
    logic                 valid;
    logic                 pending;
    logic                 done;
    logic                 settled;

    always #5 clk = ~clk;

    fir_transposed_param #(
        .NTAPS(NT), .DIN_W(DW), .COEF_W(CW), .ACC_W(AW), .DOUT_W(OW), .OUT_SHIFT(SH)
    ) dut (
        .iClk_12M     (clk),
        .iRst         (rst),
        .iEnSample    (en),
        .iFirIn       (din),
        .iCoeffWrEn   (wr),
        .iCoeffAddr   (addr),
        .iCoeffWrDt   (wdat),
        .iNumOfCoeff  (num),
        .iCoeffSwap   (swap),
        .oFirOut      (dout),
        .oFirValid    (valid),
        .oSwapPending (pending),
        .oSwapDone    (done),
        .oSettled     (settled)
    );

    int n_vec = 0;
    int n_bad = 0;

    longint sh_m [NT];
    longint ac_m [NT];
    longint hist_m [NT];
    int     nact_m;
    int     settle_m;
    bit     pend_m;
    bit     valid_m;
    bit     done_m;
    longint out_m;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic longint wrap_s(input longint v, input int w);
        longint m;
        longint r;
        m = longint'(1) << w;
        r = v & (m - 1);
        if (r >= (m >> 1)) r = r - m;
        return r;
    endfunction

    function automatic longint out_conv(input longint y);
        longint r;
        longint hi;
        longint lo;
        r  = (y + ((longint'(1) << SH) >>> 1)) >>> SH;
        hi = (longint'(1) << (OW - 1)) - 1;
        lo = -(longint'(1) << (OW - 1));
`ifdef FIR_OUT_SAT_EN
        if (r > hi) r = hi;
        if (r < lo) r = lo;
`else
        r = wrap_s(r, OW);
        if (r > hi || r < lo) r = 0;
`endif
        return r;
    endfunction

    // Advance the reference by one clock with the current inputs, then compare.
    task automatic step();
        bit     pend_old;
        longint y;
        longint xk;
        if (rst) begin
            for (int k = 0; k < NT; k++) begin
                sh_m[k] = 0; ac_m[k] = 0; hist_m[k] = 0;
            end
            nact_m = 0; settle_m = 0; pend_m = 0;
            valid_m = 0; done_m = 0; out_m = 0;
        end else begin
            pend_old = pend_m;
            valid_m  = en;
            done_m   = pend_old && en;
            if (en) begin
                y = 0;
                for (int k = 0; k < NT; k++) begin
                    xk = (k == 0) ? longint'(din) : hist_m[k-1];
                    if (k < nact_m) y += ac_m[k] * xk;
                end
                out_m = out_conv(wrap_s(y, AW));
            end
            if (done_m) begin
                for (int k = 0; k < NT; k++) begin
                    ac_m[k] = sh_m[k];
                    hist_m[k] = 0;
                end
                nact_m   = (int'(num) > NT) ? NT : int'(num);
                settle_m = (nact_m > 0) ? nact_m - 1 : 0;
                pend_m   = 0;
            end else if (en) begin
                for (int k = NT - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
                hist_m[0] = longint'(din);
                if (settle_m > 0) settle_m--;
            end
            if (!pend_old && swap) pend_m = 1;
            if (wr && int'(addr) < NT) sh_m[addr] = longint'(wdat);
        end
        @(posedge clk);
        #1;
        check_val("valid",   longint'(valid),   longint'(valid_m));
        check_val("dout",    longint'(dout),    out_m);
        check_val("pending", longint'(pending), longint'(pend_m));
        check_val("done",    longint'(done),    longint'(done_m));
        check_val("settled", longint'(settled), longint'(settle_m == 0));
    endtask

    task automatic set_idle();
        en = 1'b0; din = '0; wr = 1'b0; addr = '0; wdat = '0; swap = 1'b0;
    endtask

    task automatic strobe(input int x);
        set_idle(); en = 1'b1; din = DW'(x); step();
        set_idle();
    endtask

    task automatic write_coef(input int a, input int v);
        set_idle(); wr = 1'b1; addr = ADW'(a); wdat = CW'(v); step();
        set_idle();
    endtask

    task automatic request_swap();
        set_idle(); swap = 1'b1; step();
        set_idle(); step();
    endtask

    initial begin
        longint imp_a [5];
        longint sat_exp;
        rst = 1'b1; num = '0; set_idle();
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;
        check_val("rst_settled", longint'(settled), 1);

        // Bank {1,2,3,4,0}, nAct 4, impulse.
        for (int i = 0; i < 4; i++) write_coef(i, i + 1);
        write_coef(6, 99);
        num = NW'(4);
        request_swap();
        check_val("pend_hi", longint'(pending), 1);
        strobe(0);
        imp_a = '{1, 2, 3, 4, 0};
        for (int i = 0; i < 5; i++) begin
            strobe((i == 0) ? 1 : 0);
            check_val("imp4", longint'(dout), imp_a[i]);
            step();
        end

        // Two active taps, same bank.
        num = NW'(2);
        request_swap();
        strobe(0);
        imp_a = '{1, 2, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            strobe((i == 0) ? 1 : 0);
            check_val("imp2", longint'(dout), imp_a[i]);
        end

        // Write to h0 in the commit cycle lands in shadow only.
        request_swap();
        set_idle(); en = 1'b1; din = '0; wr = 1'b1; addr = '0; wdat = CW'(7); step();
        set_idle();
        strobe(1);
        check_val("cwr_old", longint'(dout), 1);
        request_swap();
        strobe(0);
        strobe(1);
        check_val("cwr_new", longint'(dout), 7);

        // Large coefficients, constant input 3, back-to-back strobes.
        for (int i = 0; i < NT; i++) write_coef(i, 32767);
        num = NW'(7);
        request_swap();
        strobe(0);
        for (int i = 0; i < NT; i++) strobe(3);
`ifdef FIR_OUT_SAT_EN
        sat_exp = 32767;
`else
        sat_exp = 32753;
`endif
        check_val("sat", longint'(dout), sat_exp);

        // Reset while a swap is pending.
        request_swap();
        rst = 1'b1; step(); rst = 1'b0;
        check_val("rst_pend", longint'(pending), 0);
        check_val("rst_out", longint'(dout), 0);
        strobe(3);
        check_val("rst_zero", longint'(dout), 0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 299) == 0);
            en   = ($urandom_range(0, 2) != 0);
            din  = DW'($urandom);
            wr   = ($urandom_range(0, 3) == 0);
            addr = ADW'($urandom_range(0, 7));
            wdat = CW'($urandom);
            swap = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) num = NW'($urandom_range(0, 7));
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
